// File: rtl/mul32_seq_if.sv
// Handshake bundle between the execute stage and the sequential multiplier:
// start/operands in, busy/done/product out.
interface mul32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] prod;

  modport master (output start, a, b, input  busy, done, prod);
  modport slave  (input  start, a, b, output busy, done, prod);
endinterface

// File: rtl/mul32_seq.sv
// Radix-2 shift-and-add 32x32->64 unsigned multiplier around a cla32 adder.
// Optional MUL_ZERO_BYPASS_EN: zero operands finish in one cycle.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Group generate/propagate per 4-bit block; carries look ahead across blocks
  always_comb begin
    logic v_cg;
    logic v_cb;
    logic v_gg;
    logic v_gp;
    w_c  = '0;
    v_cg = ci;
    for (int unsigned k = 0; k < 8; k++) begin
      v_gg = 1'b0;
      v_gp = 1'b1;
      v_cb = v_cg;
      for (int unsigned i = 0; i < 4; i++) begin
        w_c[4*k+i] = v_cb;
        v_cb = w_g[4*k+i] | (w_p[4*k+i] & v_cb);
        v_gg = w_g[4*k+i] | (w_p[4*k+i] & v_gg);
        v_gp = v_gp & w_p[4*k+i];
      end
      v_cg = v_gg | (v_gp & v_cg);
    end
    co = v_cg;
  end

  assign s = w_p ^ w_c;
endmodule

module mul32_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic        clk,
  input  logic        clrn,
  mul32_seq_if.slave  bus
);
  if (WIDTH != 32) begin : g_width_chk
    $error("mul32_seq: WIDTH must be 32 (internal adder is cla32)");
  end
  if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_chk
    $error("mul32_seq: CNT_W too narrow to hold 0..WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt;

  logic [WIDTH-1:0]   w_add_b;
  logic [WIDTH-1:0]   w_sum;
  logic               w_co;
  logic               w_zero_op;

  assign w_add_b = r_lo[0] ? r_mcand : '0;

  cla32 u_cla (
    .a  (r_hi),
    .b  (w_add_b),
    .ci (1'b0),
    .s  (w_sum),
    .co (w_co)
  );

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero_op = (bus.a == '0) || (bus.b == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mcand <= w_mcand_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prod  <= w_prod_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mcand_nxt = r_mcand;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_cnt_nxt   = r_cnt;
    w_prod_nxt  = r_prod;
    case (r_state)
      S_BUSY: begin
        // Carry-out re-enters at bit 63 so the 33-bit sum is never truncated
        {w_hi_nxt, w_lo_nxt} = {w_co, w_sum, r_lo[WIDTH-1:1]};
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_DONE;
          w_prod_nxt  = {w_co, w_sum, r_lo[WIDTH-1:1]};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        if (bus.start) begin
          w_mcand_nxt = bus.a;
          w_hi_nxt    = '0;
          w_lo_nxt    = bus.b;
          w_cnt_nxt   = '0;
          if (w_zero_op) begin
            w_state_nxt = S_DONE;
            w_prod_nxt  = '0;
          end else begin
            w_state_nxt = S_BUSY;
          end
        end
      end
    endcase
  end

  assign bus.busy = (r_state == S_BUSY);
  assign bus.done = (r_state == S_DONE);
  assign bus.prod = r_prod;
endmodule
